fde_sequencer: RTL

Multi-cycle instruction sequencer for the 16-bit processor. It steps each instruction through fetch, decode, execute and, where needed, memory and writeback phases. Its control strobes are registered by phase, so the datapath never sees opcode-change glitches. It drives the shared memory port through a req/ack-style wait (`mem_en` held until `mem_ack`), and it drives the PC, IR, register file, ALU and flag register enables.

---
 rtl/cpu_isa_pkg.sv | 51 +++++
 rtl/seq_wait_timer.sv | 29 ++
 rtl/fde_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 16-bit processor: opcodes, ALU function codes
// and the sequencer state encoding.
package cpu_isa_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_JMP = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB = 4'h2;
    localparam logic [OP_W-1:0] OP_AND = 4'h3;
    localparam logic [OP_W-1:0] OP_OR  = 4'h4;
    localparam logic [OP_W-1:0] OP_XOR = 4'h5;
    localparam logic [OP_W-1:0] OP_NOT = 4'h6;
    localparam logic [OP_W-1:0] OP_MOV = 4'h7;
    localparam logic [OP_W-1:0] OP_LD  = 4'h8;
    localparam logic [OP_W-1:0] OP_ST  = 4'h9;
    localparam logic [OP_W-1:0] OP_SHL = 4'hA;
    localparam logic [OP_W-1:0] OP_BE  = 4'hB;
    localparam logic [OP_W-1:0] OP_BNE = 4'hC;
    localparam logic [OP_W-1:0] OP_BLT = 4'hD;
    localparam logic [OP_W-1:0] OP_BGT = 4'hE;
    localparam logic [OP_W-1:0] OP_CMP = 4'hF;

    // ALU function codes are the opcode itself.
    localparam logic [OP_W-1:0] ALU_PASS = OP_JMP;
    localparam logic [OP_W-1:0] ALU_ADD  = OP_ADD;
    localparam logic [OP_W-1:0] ALU_SUB  = OP_SUB;
    localparam logic [OP_W-1:0] ALU_AND  = OP_AND;
    localparam logic [OP_W-1:0] ALU_OR   = OP_OR;
    localparam logic [OP_W-1:0] ALU_XOR  = OP_XOR;
    localparam logic [OP_W-1:0] ALU_NOT  = OP_NOT;
    localparam logic [OP_W-1:0] ALU_MOV  = OP_MOV;
    localparam logic [OP_W-1:0] ALU_SHL  = OP_SHL;
    localparam logic [OP_W-1:0] ALU_CMP  = OP_CMP;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    // Opcodes whose EXECUTE phase writes the ALU result to the register file.
    function automatic logic op_writes_reg(input logic [OP_W-1:0] op);
        return ((op >= OP_ADD) && (op <= OP_MOV)) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Counts consecutive memory wait cycles; o_expired flags the LIMIT-th one.
module seq_wait_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/fde_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the 16-bit CPU.
// Optional memory-wait timeout fault is built when SEQ_TIMEOUT_EN is defined.
module fde_sequencer
    import cpu_isa_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [OP_W-1:0] ir_opcode,
    input  logic            flag_eq,
    input  logic            flag_lt,
    input  logic            flag_gt,
    input  logic            mem_ack,
    output logic            ir_en,
    output logic            pc_inc,
    output logic            pc_load,
    output logic            mem_en,
    output logic            read_write,
    output logic            addr_sel,
    output logic            w_en,
    output logic            write_sel,
    output logic [OP_W-1:0] alu_func,
    output logic            flag_en,
    output logic            fetch,
    output logic            decode,
    output logic            execute,
    output logic            fault
);

    state_t          r_state;
    state_t          w_next;
    state_t          w_done;
    logic [OP_W-1:0] r_op;
    logic            w_expired;

`ifdef SEQ_TIMEOUT_EN
    logic w_waiting;

    assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEMORY);

    seq_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (!w_waiting || mem_ack),
        .i_enable  (w_waiting && !mem_ack),
        .o_expired (w_expired)
    );
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_expired        = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_op <= ir_opcode;
            end
        end
    end

    assign w_done = run ? ST_FETCH : ST_IDLE;

    // Next state and phase strobes; every output defaults low each cycle.
    always_comb begin
        w_next     = r_state;
        ir_en      = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        mem_en     = 1'b0;
        read_write = 1'b0;
        addr_sel   = 1'b0;
        w_en       = 1'b0;
        write_sel  = 1'b0;
        alu_func   = '0;
        flag_en    = 1'b0;
        fetch      = 1'b0;
        decode     = 1'b0;
        execute    = 1'b0;
        fault      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (run) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_en     = 1'b1;
                read_write = 1'b1;
                fetch      = 1'b1;
                if (mem_ack) begin
                    ir_en  = 1'b1;
                    pc_inc = 1'b1;
                    w_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                decode = 1'b1;
                w_next = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                execute  = 1'b1;
                alu_func = r_op;
                w_en     = op_writes_reg(r_op);
                w_next   = w_done;
                case (r_op)
                    OP_CMP:         flag_en = 1'b1;
                    OP_JMP:         pc_load = 1'b1;
                    OP_BE:          pc_load = flag_eq;
                    OP_BNE:         pc_load = !flag_eq;
                    OP_BLT:         pc_load = flag_lt;
                    OP_BGT:         pc_load = flag_gt;
                    OP_LD, OP_ST:   w_next  = ST_MEMORY;
                    default:        ;
                endcase
            end
            ST_MEMORY: begin
                mem_en     = 1'b1;
                addr_sel   = 1'b1;
                alu_func   = r_op;
                read_write = (r_op == OP_LD);
                if (mem_ack) begin
                    w_next = (r_op == OP_LD) ? ST_WRITEBACK : w_done;
                end
            end
            ST_WRITEBACK: begin
                w_en      = 1'b1;
                write_sel = 1'b1;
                w_next    = w_done;
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase

        if (w_expired) begin
            w_next = ST_FAULT;
        end
    end

endmodule
